// File: rtl/branch_ovf_resolver.sv
// ---------------------------------------------------------------------------
// branch_ovf_resolver
// Purpose: resolves bne/blt from the execute-stage comparator flags into a
//          registered PC redirect plus a multi-cycle flush, and turns
//          add/addi/sub overflow into a handshaked $rstatus write request.
//          Execute is stalled while a redirect or exception is in progress.
// Ports:
//   i_clock, i_reset            clock (rising edge), async active-high reset
//   i_ex_valid / o_ex_ready     execute-stage handshake (ready only in IDLE)
//   i_ex_opcode, i_ex_alu_op    instruction decode fields
//   i_ex_target                 precomputed branch target (PC+1+N)
//   i_isNotEqual, i_isLessThan  comparator flags
//   i_overflow                  ALU overflow flag
//   o_redirect_valid/o_redirect_pc  one-cycle fetch redirect and its target
//   o_flush                     squash fetch/decode, FLUSH_CYCLES cycles
//   o_stall                     NOT o_ex_ready
//   o_rstatus_valid/i_rstatus_ready/o_rstatus_data  $rstatus write request
//   o_taken_count               saturating count of taken branches
// ---------------------------------------------------------------------------
module branch_ovf_resolver #(
   parameter int unsigned PC_W         = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_ex_valid,
   output logic              o_ex_ready,
   input  logic [4:0]        i_ex_opcode,
   input  logic [4:0]        i_ex_alu_op,
   input  logic [PC_W-1:0]   i_ex_target,
   input  logic              i_isNotEqual,
   input  logic              i_isLessThan,
   input  logic              i_overflow,
   output logic              o_redirect_valid,
   output logic [PC_W-1:0]   o_redirect_pc,
   output logic              o_flush,
   output logic              o_stall,
   output logic              o_rstatus_valid,
   input  logic              i_rstatus_ready,
   output logic [31:0]       o_rstatus_data,
   output logic [CNT_W-1:0]  o_taken_count
);

   localparam int unsigned FCNT_W   = 4;
   localparam int unsigned CODE_W   = 2;
   localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_EXC_WAIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [FCNT_W-1:0]   r_flush_cnt;
   logic [FCNT_W-1:0]   w_flush_cnt_nxt;

   logic                r_redirect_valid;
   logic [PC_W-1:0]     r_redirect_pc;
   logic                r_flush;
   logic                r_rstatus_valid;
   logic [CODE_W-1:0]   r_exc_code;
   logic [CNT_W-1:0]    r_taken_count;

   logic                w_redirect_valid_nxt;
   logic [PC_W-1:0]     w_redirect_pc_nxt;
   logic                w_flush_nxt;
   logic                w_rstatus_valid_nxt;
   logic [CODE_W-1:0]   w_exc_code_nxt;
   logic [CNT_W-1:0]    w_taken_count_nxt;

   logic                w_ready;
   logic                w_accept;
   logic                w_taken;
   logic [CODE_W-1:0]   w_code;
   logic                w_exc;

   // Decode of the presented instruction; only meaningful when w_accept.
   always_comb begin
      w_ready  = (r_state == S_IDLE);
      w_accept = i_ex_valid && w_ready;
      w_taken  = ((i_ex_opcode == OP_BNE) && i_isNotEqual) ||
                 ((i_ex_opcode == OP_BLT) && i_isLessThan);
      w_code   = '0;
      if (i_overflow) begin
         if ((i_ex_opcode == OP_RTYPE) && (i_ex_alu_op == ALU_ADD))
            w_code = 2'd1;
         else if (i_ex_opcode == OP_ADDI)
            w_code = 2'd2;
         else if ((i_ex_opcode == OP_RTYPE) && (i_ex_alu_op == ALU_SUB))
            w_code = 2'd3;
      end
      w_exc = (w_code != '0);
   end

   // State register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // Next-state logic; the flush counter tracks remaining flush cycles.
   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_taken) begin
               w_state_nxt     = S_FLUSH;
               w_flush_cnt_nxt = FLUSH_LOAD;
            end else if (w_accept && w_exc) begin
               w_state_nxt = S_EXC_WAIT;
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt == '0)
               w_state_nxt = S_IDLE;
            else
               w_flush_cnt_nxt = r_flush_cnt - FCNT_W'(1);
         end
         S_EXC_WAIT: begin
            if (i_rstatus_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      w_redirect_valid_nxt = w_accept && w_taken;
      w_redirect_pc_nxt    = r_redirect_pc;
      w_exc_code_nxt       = r_exc_code;
      w_taken_count_nxt    = r_taken_count;
      w_flush_nxt          = (w_state_nxt == S_FLUSH);
      w_rstatus_valid_nxt  = (w_state_nxt == S_EXC_WAIT);
      if (w_accept && w_taken) begin
         w_redirect_pc_nxt = i_ex_target;
         if (r_taken_count != '1)
            w_taken_count_nxt = r_taken_count + CNT_W'(1);
      end
      if (w_accept && !w_taken && w_exc)
         w_exc_code_nxt = w_code;
   end

   // Output registers.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_flush          <= 1'b0;
         r_rstatus_valid  <= 1'b0;
         r_exc_code       <= '0;
         r_taken_count    <= '0;
      end else begin
         r_redirect_valid <= w_redirect_valid_nxt;
         r_redirect_pc    <= w_redirect_pc_nxt;
         r_flush          <= w_flush_nxt;
         r_rstatus_valid  <= w_rstatus_valid_nxt;
         r_exc_code       <= w_exc_code_nxt;
         r_taken_count    <= w_taken_count_nxt;
      end
   end

   // Handshake outputs decode from state only: no path from the flag inputs.
   assign o_ex_ready       = w_ready;
   assign o_stall          = !w_ready;
   assign o_redirect_valid = r_redirect_valid;
   assign o_redirect_pc    = r_redirect_pc;
   assign o_flush          = r_flush;
   assign o_rstatus_valid  = r_rstatus_valid;
   assign o_rstatus_data   = {{(32 - CODE_W){1'b0}}, r_exc_code};
   assign o_taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_ovf_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_ovf_resolver
// Purpose: directed self-checking bench. u_dut uses default parameters; u_sat
//          uses a 4-bit counter and single-cycle flush so counter saturation
//          and the shortest flush are reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_branch_ovf_resolver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_valid2 = 1'b0;
   logic [4:0]  ex_opcode = 5'b11111;
   logic [4:0]  ex_alu_op = 5'b11111;
   logic [31:0] ex_target = '0;
   logic        ne = 1'b0;
   logic        lt = 1'b0;
   logic        ovf = 1'b0;
   logic        rs_ready = 1'b0;

   logic        ex_ready, redirect_valid, flush, stall, rs_valid;
   logic [31:0] redirect_pc, rs_data;
   logic [15:0] taken_count;

   logic        ex_ready2, redirect_valid2, flush2, stall2, rs_valid2;
   logic [31:0] redirect_pc2, rs_data2;
   logic [3:0]  taken_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_ovf_resolver u_dut (
      .i_clock(clk), .i_reset(rst), .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
      .i_ex_opcode(ex_opcode), .i_ex_alu_op(ex_alu_op), .i_ex_target(ex_target),
      .i_isNotEqual(ne), .i_isLessThan(lt), .i_overflow(ovf),
      .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
      .o_flush(flush), .o_stall(stall), .o_rstatus_valid(rs_valid),
      .i_rstatus_ready(rs_ready), .o_rstatus_data(rs_data),
      .o_taken_count(taken_count)
   );

   branch_ovf_resolver #(.PC_W(32), .FLUSH_CYCLES(1), .CNT_W(4)) u_sat (
      .i_clock(clk), .i_reset(rst), .i_ex_valid(ex_valid2), .o_ex_ready(ex_ready2),
      .i_ex_opcode(ex_opcode), .i_ex_alu_op(ex_alu_op), .i_ex_target(ex_target),
      .i_isNotEqual(ne), .i_isLessThan(lt), .i_overflow(ovf),
      .o_redirect_valid(redirect_valid2), .o_redirect_pc(redirect_pc2),
      .o_flush(flush2), .o_stall(stall2), .o_rstatus_valid(rs_valid2),
      .i_rstatus_ready(rs_ready), .o_rstatus_data(rs_data2),
      .o_taken_count(taken_count2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, ".ex_ready"}, 64'(ex_ready), 64'(1));
      chk({tag, ".stall"}, 64'(stall), 64'(0));
      chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(0));
      chk({tag, ".flush"}, 64'(flush), 64'(0));
      chk({tag, ".rstatus_valid"}, 64'(rs_valid), 64'(0));
   endtask

   initial begin
      // Reset state
      #2;
      idle_outs("rst");
      chk("rst.redirect_pc", 64'(redirect_pc), 64'(0));
      chk("rst.rstatus_data", 64'(rs_data), 64'(0));
      chk("rst.taken_count", 64'(taken_count), 64'(0));
      tick(); tick();
      rst = 1'b0;
      tick();

      // bne taken -> redirect to 0x40, flush 2 cycles, ready 3 cycles after accept
      ex_valid = 1'b1; ex_opcode = 5'b00010; ex_target = 32'h40; ne = 1'b1;
      tick();
      chk("bne.redirect_valid", 64'(redirect_valid), 64'(1));
      chk("bne.redirect_pc", 64'(redirect_pc), 64'h40);
      chk("bne.flush1", 64'(flush), 64'(1));
      chk("bne.ex_ready1", 64'(ex_ready), 64'(0));
      chk("bne.stall1", 64'(stall), 64'(1));
      chk("bne.taken_count", 64'(taken_count), 64'(1));
      // ex_valid held with another taken bne during FLUSH must be ignored
      ex_target = 32'h80;
      tick();
      ex_valid = 1'b0;
      chk("bne.redirect_once", 64'(redirect_valid), 64'(0));
      chk("bne.flush2", 64'(flush), 64'(1));
      chk("bne.ex_ready2", 64'(ex_ready), 64'(0));
      chk("bne.pc_held", 64'(redirect_pc), 64'h40);
      tick();
      idle_outs("bne.done");
      chk("bne.count_after_ignore", 64'(taken_count), 64'(1));
      ne = 1'b0;

      // blt not taken then immediate blt taken
      ex_valid = 1'b1; ex_opcode = 5'b00110; lt = 1'b0; ex_target = 32'h100;
      tick();
      idle_outs("blt_nt");
      chk("blt_nt.count", 64'(taken_count), 64'(1));
      lt = 1'b1; ex_target = 32'h200;
      tick();
      ex_valid = 1'b0; lt = 1'b0;
      chk("blt_t.redirect_valid", 64'(redirect_valid), 64'(1));
      chk("blt_t.redirect_pc", 64'(redirect_pc), 64'h200);
      chk("blt_t.count", 64'(taken_count), 64'(2));
      tick(); tick();
      idle_outs("blt.done");

      // sub overflow, rstatus_ready low 4 cycles then high
      ex_valid = 1'b1; ex_opcode = 5'b00000; ex_alu_op = 5'b00001; ovf = 1'b1;
      rs_ready = 1'b0;
      tick();
      ex_valid = 1'b0; ovf = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("sub.valid%0d", i), 64'(rs_valid), 64'(1));
         chk($sformatf("sub.data%0d", i), 64'(rs_data), 64'(3));
         chk($sformatf("sub.ex_ready%0d", i), 64'(ex_ready), 64'(0));
         chk($sformatf("sub.no_flush%0d", i), 64'(flush), 64'(0));
         if (i == 4) rs_ready = 1'b1;
         tick();
      end
      idle_outs("sub.done");
      rs_ready = 1'b0;

      // addi overflow with ready constantly high -> one valid cycle, code 2
      rs_ready = 1'b1;
      ex_valid = 1'b1; ex_opcode = 5'b00101; ovf = 1'b1;
      tick();
      ex_valid = 1'b0;
      chk("addi.valid", 64'(rs_valid), 64'(1));
      chk("addi.data", 64'(rs_data), 64'(2));
      chk("addi.no_redirect", 64'(redirect_valid), 64'(0));
      tick();
      idle_outs("addi.done");

      // add overflow -> code 1
      ex_valid = 1'b1; ex_opcode = 5'b00000; ex_alu_op = 5'b00000;
      tick();
      ex_valid = 1'b0;
      chk("add.valid", 64'(rs_valid), 64'(1));
      chk("add.data", 64'(rs_data), 64'(1));
      tick();
      idle_outs("add.done");

      // R-type with unknown alu_op and overflow -> no action
      ex_valid = 1'b1; ex_alu_op = 5'b00010;
      tick();
      idle_outs("rtype_other");
      // bne with overflow and isNotEqual = 0 -> no exception, no redirect
      ex_opcode = 5'b00010; ne = 1'b0;
      tick();
      ex_valid = 1'b0; ovf = 1'b0; rs_ready = 1'b0;
      idle_outs("bne_ovf");
      chk("bne_ovf.count", 64'(taken_count), 64'(2));

      // Reset during the second flush cycle
      ex_valid = 1'b1; ex_opcode = 5'b00010; ne = 1'b1; ex_target = 32'h300;
      tick();
      ex_valid = 1'b0; ne = 1'b0;
      tick();
      chk("midflush.flush", 64'(flush), 64'(1));
      rst = 1'b1;
      #1;
      idle_outs("midflush.rst");
      chk("midflush.redirect_pc", 64'(redirect_pc), 64'(0));
      chk("midflush.count", 64'(taken_count), 64'(0));
      tick();
      rst = 1'b0;
      tick();
      idle_outs("midflush.after");

      // Saturation and single-cycle flush on the 4-bit instance
      ex_opcode = 5'b00010; ne = 1'b1; ex_target = 32'h44;
      for (int i = 0; i < 15; i++) begin
         ex_valid2 = 1'b1;
         tick();
         ex_valid2 = 1'b0;
         tick();
      end
      chk("sat.count15", 64'(taken_count2), 64'hF);
      ex_valid2 = 1'b1;
      tick();
      ex_valid2 = 1'b0;
      chk("sat.redirect_valid", 64'(redirect_valid2), 64'(1));
      chk("sat.flush", 64'(flush2), 64'(1));
      chk("sat.count_held", 64'(taken_count2), 64'hF);
      tick();
      chk("sat.flush_end", 64'(flush2), 64'(0));
      chk("sat.ex_ready", 64'(ex_ready2), 64'(1));
      chk("sat.main_untouched", 64'(taken_count), 64'(0));
      ne = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
